// File: rtl/vol_ramp_ctrl.sv
// Per-channel volume controller: SPI-written target gains and live gains that
// slew toward their targets by at most RAMP_STEP once per audio frame.
module vol_ramp_ctrl #(
  parameter int          NUM_CH    = 1,
  parameter logic [15:0] RAMP_STEP = 16'h0004,
  parameter logic [15:0] VOL_RESET = 16'h00ff
) (
  input  logic                   clk245760,
  input  logic                   rst,
  input  logic                   spi_sclk_i,
  input  logic                   spi_cs_n_i,
  input  logic                   spi_mosi_i,
  output logic                   spi_miso_o,
  input  logic                   frame_tick_i,
  output logic [NUM_CH*32-1:0]   vol_o,
  output logic                   busy_o
);

  localparam int NG = 2 * NUM_CH;

  logic [2:0]  sclk_sync_reg;
  logic [1:0]  cs_sync_reg;
  logic [1:0]  mosi_sync_reg;
  logic        cs_s;
  logic        mosi_s;
  logic        sclk_rise;
  logic        sclk_fall;

  logic        armed_reg;
  logic [4:0]  cnt_reg;
  logic [22:0] rx_reg;
  logic [15:0] tx_reg;
  logic        miso_reg;
  logic        busy_reg;

  logic [6:0]  rd_addr;
  logic [15:0] rd_data;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [15:0] wr_data;

  logic [NG*16-1:0] target_flat;
  logic [NG-1:0]    differ_vec;

  assign cs_s      = cs_sync_reg[1];
  assign mosi_s    = mosi_sync_reg[1];
  assign sclk_rise = sclk_sync_reg[1] & ~sclk_sync_reg[2];
  assign sclk_fall = ~sclk_sync_reg[1] & sclk_sync_reg[2];

  // Address bits are complete on the 8th rise; data word on the 24th.
  assign rd_addr = {rx_reg[5:0], mosi_s};
  assign wr_addr = rx_reg[21:15];
  assign wr_data = {rx_reg[14:0], mosi_s};
  assign wr_en   = sclk_rise && armed_reg && !cs_s && (cnt_reg == 5'd23) && rx_reg[22];

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NG; k++) begin
      if (rd_addr == 7'(k))
        rd_data = target_flat[16*k +: 16];
      if (rd_addr == 7'(7'h40 + k))
        rd_data = vol_o[16*k +: 16];
    end
    if (rd_addr == 7'h7f)
      rd_data = 16'hD000 | 16'(NUM_CH);
  end

  // cs_n sync resets to "asserted" so a frame in flight across reset is
  // ignored until a genuine idle-high chip select has been observed.
  always_ff @(posedge clk245760) begin
    if (rst) begin
      sclk_sync_reg <= '0;
      cs_sync_reg   <= '0;
      mosi_sync_reg <= '0;
      armed_reg     <= 1'b0;
      cnt_reg       <= '0;
      rx_reg        <= '0;
      tx_reg        <= '0;
      miso_reg      <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[1:0], spi_sclk_i};
      cs_sync_reg   <= {cs_sync_reg[0], spi_cs_n_i};
      mosi_sync_reg <= {mosi_sync_reg[0], spi_mosi_i};
      if (cs_s)
        armed_reg <= 1'b1;
      if (cs_s || !armed_reg) begin
        cnt_reg  <= '0;
        miso_reg <= 1'b0;
      end else begin
        if (sclk_rise && (cnt_reg != 5'd24)) begin
          cnt_reg <= cnt_reg + 5'd1;
          rx_reg  <= {rx_reg[21:0], mosi_s};
          if (cnt_reg == 5'd7)
            tx_reg <= rd_data;
        end
        if (sclk_fall) begin
          if ((cnt_reg >= 5'd8) && (cnt_reg <= 5'd23)) begin
            miso_reg <= tx_reg[15];
            tx_reg   <= {tx_reg[14:0], 1'b0};
          end else begin
            miso_reg <= 1'b0;
          end
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_lane
      logic [15:0] target_reg;
      logic [15:0] live_reg;
      logic [15:0] target_next;
      logic [15:0] live_next;
      logic [15:0] stepped;
      logic [15:0] up_gap;
      logic [15:0] dn_gap;

      assign up_gap = target_reg - live_reg;
      assign dn_gap = live_reg - target_reg;

      // Gap is compared before stepping, so the result never overshoots or wraps.
      always_comb begin
        stepped = live_reg;
        if (live_reg < target_reg)
          stepped = (up_gap > RAMP_STEP) ? live_reg + RAMP_STEP : target_reg;
        else if (live_reg > target_reg)
          stepped = (dn_gap > RAMP_STEP) ? live_reg - RAMP_STEP : target_reg;
      end

      always_comb begin
        target_next = target_reg;
        if (wr_en && (wr_addr == 7'(gi)))
          target_next = wr_data;
        live_next = frame_tick_i ? stepped : live_reg;
      end

      always_ff @(posedge clk245760) begin
        if (rst) begin
          target_reg <= VOL_RESET;
          live_reg   <= VOL_RESET;
        end else begin
          target_reg <= target_next;
          live_reg   <= live_next;
        end
      end

      assign target_flat[16*gi +: 16] = target_reg;
      assign vol_o[16*gi +: 16]       = live_reg;
      assign differ_vec[gi]           = (live_next != target_next);
    end
  endgenerate

  always_ff @(posedge clk245760) begin
    if (rst)
      busy_reg <= 1'b0;
    else
      busy_reg <= |differ_vec;
  end

  assign busy_o     = busy_reg;
  assign spi_miso_o = miso_reg;

endmodule

// File: tb/tb_vol_ramp_ctrl.sv
// Directed plus randomized bench for vol_ramp_ctrl (NUM_CH=1) with a
// gain-level reference model of targets, live gains and register readback.
module tb_vol_ramp_ctrl;

  localparam int HALF = 8;

  logic        clk245760 = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic        tick = 1'b0;
  logic [31:0] vol;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] tgt  [2];
  logic [15:0] live [2];

  vol_ramp_ctrl #(.NUM_CH(1), .RAMP_STEP(16'h0004), .VOL_RESET(16'h00ff)) dut (
    .clk245760    (clk245760),
    .rst          (rst),
    .spi_sclk_i   (sclk),
    .spi_cs_n_i   (cs_n),
    .spi_mosi_i   (mosi),
    .spi_miso_o   (miso),
    .frame_tick_i (tick),
    .vol_o        (vol),
    .busy_o       (busy)
  );

  always #20 clk245760 = ~clk245760;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_busy();
    return (tgt[0] != live[0]) || (tgt[1] != live[1]);
  endfunction

  function automatic logic [15:0] model_read(input logic [6:0] a);
    if (a < 7'd2)                      return tgt[a[0]];
    if (a == 7'h40 || a == 7'h41)      return live[a[0]];
    if (a == 7'h7f)                    return 16'hD001;
    return 16'h0000;
  endfunction

  // Each gain moves toward its target by the gap clamped to +/-4.
  task automatic model_tick();
    for (int k = 0; k < 2; k++) begin
      int d;
      d = int'(tgt[k]) - int'(live[k]);
      if (d > 4)  d = 4;
      if (d < -4) d = -4;
      live[k] = 16'(int'(live[k]) + d);
    end
  endtask

  task automatic do_tick(input string tag);
    @(negedge clk245760);
    tick = 1'b1;
    model_tick();
    @(negedge clk245760);
    tick = 1'b0;
    chk({tag, "_vol"}, vol, {live[1], live[0]});
    chk({tag, "_busy"}, {31'b0, busy}, {31'b0, model_busy()});
  endtask

  // Drives one frame of nbits; optionally pulses frame_tick_i so it lands on
  // the same clock as the commit of the 24th bit.
  task automatic spi_xfer(input logic [23:0] word, input int nbits, input bit collide,
                          output logic [15:0] rd);
    rd = '0;
    @(negedge clk245760);
    cs_n = 1'b0;
    repeat (4) @(negedge clk245760);
    for (int i = 0; i < nbits; i++) begin
      mosi = word[23-i];
      repeat (HALF) @(negedge clk245760);
      if (i >= 8) rd = {rd[14:0], miso};
      sclk = 1'b1;
      if (collide && i == nbits - 1) begin
        repeat (2) @(negedge clk245760);
        tick = 1'b1;
        model_tick();
        @(negedge clk245760);
        tick = 1'b0;
        repeat (HALF - 3) @(negedge clk245760);
      end else begin
        repeat (HALF) @(negedge clk245760);
      end
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk245760);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clk245760);
    if (nbits == 24 && word[23] && word[22:16] < 7'd2)
      tgt[word[16]] = word[15:0];
    $display("spi %s addr=%h data=%h bits=%0d rd=%h", word[23] ? "wr" : "rd",
             word[22:16], word[15:0], nbits, rd);
  endtask

  task automatic spi_write(input string tag, input logic [6:0] a, input logic [15:0] d,
                           input bit collide);
    logic [15:0] rd;
    spi_xfer({1'b1, a, d}, 24, collide, rd);
    chk({tag, "_busy"}, {31'b0, busy}, {31'b0, model_busy()});
    chk({tag, "_vol"}, vol, {live[1], live[0]});
  endtask

  task automatic spi_read(input string tag, input logic [6:0] a);
    logic [15:0] rd;
    spi_xfer({1'b0, a, 16'h0000}, 24, 1'b0, rd);
    chk(tag, {16'h0, rd}, {16'h0, model_read(a)});
  endtask

  initial begin
    logic [15:0] rd;
    logic [15:0] up_seq [5];
    logic [6:0]  pick [6];
    up_seq = '{16'h0103, 16'h0107, 16'h010B, 16'h010F, 16'h0110};
    pick   = '{7'h00, 7'h01, 7'h40, 7'h41, 7'h7f, 7'h00};
    tgt  = '{16'h00ff, 16'h00ff};
    live = '{16'h00ff, 16'h00ff};

    // Reset and idle readback
    repeat (2) @(negedge clk245760);
    rst = 1'b0;
    @(negedge clk245760);
    chk("rst_vol", vol, 32'h00ff00ff);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_miso", {31'b0, miso}, 32'h0);
    spi_read("rd_id", 7'h7f);
    spi_read("rd_live0_init", 7'h40);
    spi_read("rd_unmapped", 7'h05);
    chk("idle_miso", {31'b0, miso}, 32'h0);

    // Upward ramp
    spi_write("wr_up", 7'h00, 16'h0110, 1'b0);
    chk("up_busy_rise", {31'b0, busy}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      do_tick("up_tick");
      chk("up_seq", {16'h0, vol[15:0]}, {16'h0, up_seq[i]});
    end
    chk("up_busy_done", {31'b0, busy}, 32'h0);

    // Downward ramp clamps at zero
    spi_write("wr_down", 7'h01, 16'h0000, 1'b0);
    for (int i = 0; i < 64; i++) begin
      if (i == 63) chk("down_pre_last", {16'h0, vol[31:16]}, 32'h0003);
      do_tick("down_tick");
    end
    chk("down_final", {16'h0, vol[31:16]}, 32'h0000);
    chk("down_busy", {31'b0, busy}, 32'h0);
    do_tick("idle_tick");

    // Aborted frame, then a normal one
    spi_xfer({1'b1, 7'h00, 16'hBEEF}, 20, 1'b0, rd);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    spi_read("abort_rd", 7'h00);
    spi_write("wr_1234", 7'h00, 16'h1234, 1'b0);
    spi_read("rd_1234", 7'h00);
    spi_write("wr_settle", 7'h00, 16'h0110, 1'b0);
    chk("settle_busy", {31'b0, busy}, 32'h0);

    // Write commits on the same clock as the frame tick
    spi_write("wr_collide", 7'h00, 16'h0200, 1'b1);
    chk("collide_vol", {16'h0, vol[15:0]}, 32'h0110);
    do_tick("post_collide");
    chk("post_collide_vol", {16'h0, vol[15:0]}, 32'h0114);

    // Randomized traffic
    for (int it = 0; it < 25; it++) begin
      logic [6:0] a;
      a = pick[$urandom_range(0, 5)];
      if (it % 6 == 5) a = 7'($urandom);
      if ($urandom_range(0, 1) == 1) spi_write("rnd_wr", a, 16'($urandom), 1'b0);
      else                           spi_read("rnd_rd", a);
      for (int t = 0; t < int'($urandom_range(0, 6)); t++) do_tick("rnd_tick");
    end
    spi_read("rnd_final_live0", 7'h40);
    spi_read("rnd_final_live1", 7'h41);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vol_ramp_ctrl.md
# vol_ramp_ctrl

SPI-configured volume controller for the mixer. It holds a target gain per channel and side, written over the config SPI port. It ramps the live gains toward those targets in fixed steps once per audio frame, so a gain change does not produce zipper noise. It drives the mixer `vol_i` bus and sits between the config SPI pins and the mixer, in the clk245760 domain.

## Interface
- NUM_CH, 1, number of stereo input channels; gain count is 2*NUM_CH
- RAMP_STEP, 16'h0004, maximum change of a live gain per frame tick
- VOL_RESET, 16'h00ff, reset value of every target and live gain
- clk245760  in  1  system clock, 24.576 MHz
- rst  in  1  reset: synchronous, active-high; clock clk245760
- spi_sclk_i  in  1  config SPI clock, asynchronous, mode 0, ≤ 3 MHz
- spi_cs_n_i  in  1  config SPI chip select, active-low, asynchronous
- spi_mosi_i  in  1  config SPI data in, MSB first
- spi_miso_o  out  1  config SPI data out
- frame_tick_i  in  1  one-cycle pulse per stereo frame; the mixer's right-side ack is wired here
- vol_o  out  NUM_CH*32  live gains; index k = 2*c + s (s=0 L, s=1 R) occupies vol_o[16k +: 16]
- busy_o  out  1  high while any live gain differs from its target

## Operation
- SPI input path: sclk, cs_n and mosi each pass through a 2-FF synchronizer. Rise and fall are detected on the synchronized sclk, using a third register.
- Frame: 24 bits while cs_n is low.
  - bit 23: R/W, 1 = write.
  - bits 22:16: address.
  - bits 15:0: data.
- Bit counter:
  - Cleared while cs_n is high.
  - Counts sampled rising edges and saturates at 24.
  - Bits beyond 24 are ignored. At most one write occurs per frame.
- Address map:
  - 0..2*NUM_CH-1: target gain k, read/write.
  - 0x40+k: live gain k, read-only.
  - 0x7F: ID, read-only, value 16'hD000 | NUM_CH.
  - Any other address reads 0. Writes to read-only or unmapped addresses are dropped.
- Write: target[addr] <= data on the cycle the 24th rising edge is detected, provided bit 23 = 1 and cs_n is still low.
- cs_n rising before 24 bits aborts the frame with no write.
- Read:
  - After the 8th rising edge, readback data is latched into the 16-bit output shift register.
  - miso shifts out MSB first on each following detected falling edge, so the master samples bit 15 on the 9th rising edge.
  - miso is 0 during bits 23:16 and whenever cs_n is high.
- Ramp, on each frame_tick_i, for every k in parallel:
  - If live < target: live <= (target - live > RAMP_STEP) ? live + RAMP_STEP : target.
  - If live > target: the symmetric decrement.
  - If live == target: unchanged.
- Arithmetic is unsigned 16-bit. The difference is computed before adding, so the step never overflows or overshoots.
- vol_o is the registered live gains. busy_o is registered: it is the OR over k of (live != target).

## Timing
- Reset values:
  - All targets and live gains = VOL_RESET.
  - vol_o = {2*NUM_CH{VOL_RESET}}.
  - busy_o = 0, spi_miso_o = 0.
  - Bit counter = 0, shift registers = 0.
- Reset mid-SPI-frame discards the frame. The next frame is accepted only after cs_n has been seen high.
- Latency from SPI pin edge to detected edge is 3 cycles. A target write therefore lands 3-4 cycles after the 24th sclk pin rise.
- vol_o changes exactly 1 cycle after frame_tick_i and at no other time.
- busy_o updates 1 cycle after any target write or ramp step.
- Write and frame_tick_i in the same cycle: the ramp uses the old target. The new target affects the next tick.
- frame_tick_i while live == target for all k: vol_o and busy_o stay unchanged.
- Back-to-back frames need cs_n high for ≥ 4 clk245760 cycles between them.

## Test plan
- Reset: assert rst 2 cycles → vol_o all 16'h00ff, busy_o 0, miso 0; read addr 0x7F → 16'hD001 (NUM_CH=1).
- Upward ramp: write addr 0 = 16'h0110 → busy_o rises. Exactly 5 ticks take vol_o[15:0] through 0x0103, 0x0107, 0x010B, 0x010F, 0x0110. busy_o goes 0 one cycle after the 5th tick.
- Downward ramp with clamp: write addr 1 = 16'h0000 from 16'h00ff → 64 ticks to reach 0, last step 0x0003→0x0000. There is no wrap to 0xFFFC.
- Abort: cs_n rises after 20 bits of a write to addr 0 → target unchanged, busy_o stays 0; the next full frame is accepted normally.
- Readback: write addr 0 = 16'h1234, then read addr 0 → miso returns 16'h1234. Read 0x40 before any tick → 16'h00ff. Read 0x05 → 16'h0000.
- Collision: a write to addr 0 commits in the same cycle as frame_tick_i → that tick leaves vol_o unchanged (old target == live). The next tick steps toward the new value.
